// File: rtl/branch_ctrl.sv
// branch_ctrl: branch/call/return resolution between decode and the PC mux.
//
// Holds a 3-bit condition register, a run-time-writable branch target table
// and a circular return-address stack (RAS). branch/address are combinational
// from the current decode inputs and registered state; all state updates on
// the rising clock edge.
//
// Parameters:
//   ADDR_W    - PC / target address width
//   IMM_W     - branch immediate (table index) width
//   TBL_DEPTH - target table entries (<= 2**IMM_W)
//   RAS_DEPTH - return-address stack entries (power of 2, >= 2)
//
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   equal, less           - comparator results
//   w_flag, flag_in       - condition register write
//   branch_instr, call_instr, ret_instr - decode strobes (ret > call > branch)
//   immediate, pc         - table index, current PC
//   tbl_we/waddr/wdata    - target table write port
//   address, branch       - redirect target and take-redirect
//   ras_ovf               - sticky push-while-full
//   ras_unf               - one-cycle pulse after a return on an empty RAS
//   taken_cnt, not_taken_cnt - statistics counters
//
// Optional feature macro BRANCH_STATS_EN: when defined, taken_cnt and
// not_taken_cnt are saturating 16-bit counters; otherwise both read 0.

module branch_ctrl #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned IMM_W     = 5,
  parameter int unsigned TBL_DEPTH = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              equal,
  input  logic              less,
  input  logic              w_flag,
  input  logic [2:0]        flag_in,
  input  logic              branch_instr,
  input  logic              call_instr,
  input  logic              ret_instr,
  input  logic [IMM_W-1:0]  immediate,
  input  logic [ADDR_W-1:0] pc,
  input  logic              tbl_we,
  input  logic [IMM_W-1:0]  tbl_waddr,
  input  logic [ADDR_W-1:0] tbl_wdata,
  output logic [ADDR_W-1:0] address,
  output logic              branch,
  output logic              ras_ovf,
  output logic              ras_unf,
  output logic [15:0]       taken_cnt,
  output logic [15:0]       not_taken_cnt
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] RAS_FULL  = CNT_W'(RAS_DEPTH);
  localparam logic [IMM_W:0]   TBL_LIMIT = (IMM_W + 1)'(TBL_DEPTH);

  logic [2:0]        flag_q, flag_d;
  logic [ADDR_W-1:0] tbl_q [TBL_DEPTH];
  logic [ADDR_W-1:0] tbl_d [TBL_DEPTH];
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr_q, ras_ptr_d;   // next free slot
  logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
  logic              ras_ovf_q, ras_ovf_d;
  logic              ras_unf_q, ras_unf_d;

  logic              cond;
  logic              ret_win, call_win, br_win;
  logic              ras_empty;
  logic              rd_in_range, wr_in_range;
  logic [ADDR_W-1:0] tbl_rd;
  logic [PTR_W-1:0]  ras_top_idx;
  logic [ADDR_W-1:0] pc_inc;

  // Condition evaluated on the registered flag, so a same-cycle w_flag
  // only affects the following cycle.
  always_comb begin
    cond = 1'b0;
    case (flag_q)
      3'b000:  cond = ~equal;
      3'b001:  cond = equal;
      3'b010:  cond = less;
      3'b011:  cond = less | equal;
      3'b100:  cond = 1'b1;
      3'b101:  cond = ~less;
      3'b110:  cond = ~less & ~equal;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    ret_win     = ret_instr;
    call_win    = call_instr & ~ret_instr;
    br_win      = branch_instr & ~ret_instr & ~call_instr;
    ras_empty   = (ras_cnt_q == '0);
    rd_in_range = ({1'b0, immediate} < TBL_LIMIT);
    wr_in_range = ({1'b0, tbl_waddr} < TBL_LIMIT);
    tbl_rd      = rd_in_range ? tbl_q[immediate] : '0;
    ras_top_idx = ras_ptr_q - PTR_W'(1);
    pc_inc      = pc + ADDR_W'(1);
  end

  always_comb begin
    branch  = 1'b0;
    address = tbl_rd;
    if (ret_win) begin
      branch  = ~ras_empty;
      address = ras_empty ? '0 : ras_q[ras_top_idx];
    end else if (call_win) begin
      branch  = 1'b1;
    end else if (br_win) begin
      branch  = cond;
    end
    if (!reset) begin
      branch = 1'b0;
    end
  end

  always_comb begin
    flag_d = w_flag ? flag_in : flag_q;
    tbl_d  = tbl_q;
    if (tbl_we && wr_in_range) begin
      tbl_d[tbl_waddr] = tbl_wdata;
    end
  end

  // Full + push overwrites the slot at the write pointer, which holds the
  // oldest entry, so the stack behaves as a circular buffer.
  always_comb begin
    ras_d     = ras_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_ovf_d = ras_ovf_q;
    ras_unf_d = 1'b0;
    if (ret_win) begin
      if (ras_empty) begin
        ras_unf_d = 1'b1;
      end else begin
        ras_ptr_d = ras_ptr_q - PTR_W'(1);
        ras_cnt_d = ras_cnt_q - CNT_W'(1);
      end
    end else if (call_win) begin
      ras_d[ras_ptr_q] = pc_inc;
      ras_ptr_d        = ras_ptr_q + PTR_W'(1);
      if (ras_cnt_q == RAS_FULL) begin
        ras_ovf_d = 1'b1;
      end else begin
        ras_cnt_d = ras_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flag_q    <= '0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
      ras_ovf_q <= 1'b0;
      ras_unf_q <= 1'b0;
      for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      flag_q    <= flag_d;
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
      ras_ovf_q <= ras_ovf_d;
      ras_unf_q <= ras_unf_d;
      for (int unsigned i = 0; i < TBL_DEPTH; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= ras_d[i];
      end
    end
  end

  assign ras_ovf = ras_ovf_q;
  assign ras_unf = ras_unf_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] not_taken_cnt_q, not_taken_cnt_d;

  always_comb begin
    taken_cnt_d     = taken_cnt_q;
    not_taken_cnt_d = not_taken_cnt_q;
    if (branch && (taken_cnt_q != '1)) begin
      taken_cnt_d = taken_cnt_q + 16'd1;
    end
    if (br_win && !cond && (not_taken_cnt_q != '1)) begin
      not_taken_cnt_d = not_taken_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else begin
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end

  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;
`else
  assign taken_cnt     = '0;
  assign not_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl (TBL_DEPTH overridden to 24 so the
// out-of-range table index path is reachable with a 5-bit immediate).
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        reset, equal, less, w_flag;
  logic [2:0]  flag_in;
  logic        branch_instr, call_instr, ret_instr;
  logic [4:0]  immediate;
  logic [9:0]  pc;
  logic        tbl_we;
  logic [4:0]  tbl_waddr;
  logic [9:0]  tbl_wdata;
  logic [9:0]  address;
  logic        branch, ras_ovf, ras_unf;
  logic [15:0] taken_cnt, not_taken_cnt;

  branch_ctrl #(
    .ADDR_W(10),
    .IMM_W(5),
    .TBL_DEPTH(24),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .equal(equal), .less(less),
    .w_flag(w_flag), .flag_in(flag_in),
    .branch_instr(branch_instr), .call_instr(call_instr), .ret_instr(ret_instr),
    .immediate(immediate), .pc(pc),
    .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
    .address(address), .branch(branch), .ras_ovf(ras_ovf), .ras_unf(ras_unf),
    .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
  );

  always #5 clk = ~clk;

  // inputs: rst wf fi eq ls br ca re imm pc twe twa twd | expected: eb ea eovf eunf
  typedef struct {
    int rst, wf, fi, eq, ls, br, ca, re, imm, pc, twe, twa, twd;
    int eb, ea, eovf, eunf;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   vidx   = 0;

  task automatic chk(input string nm, input int id, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s step%0d: got %0d expected %0d", nm, id, act, exp);
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    reset        = v.rst[0];
    w_flag       = v.wf[0];
    flag_in      = v.fi[2:0];
    equal        = v.eq[0];
    less         = v.ls[0];
    branch_instr = v.br[0];
    call_instr   = v.ca[0];
    ret_instr    = v.re[0];
    immediate    = v.imm[4:0];
    pc           = v.pc[9:0];
    tbl_we       = v.twe[0];
    tbl_waddr    = v.twa[4:0];
    tbl_wdata    = v.twd[9:0];
    sb.push_back(v);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", vidx, 0, 1);
    end else begin
      e = sb.pop_front();
      chk("branch",  vidx, int'(branch),  e.eb);
      chk("address", vidx, int'(address), e.ea);
      chk("ras_ovf", vidx, int'(ras_ovf), e.eovf);
      chk("ras_unf", vidx, int'(ras_unf), e.eunf);
    end
    vidx++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; w_flag = 1'b0; flag_in = '0; equal = 1'b0; less = 1'b0;
    branch_instr = 1'b0; call_instr = 1'b0; ret_instr = 1'b0;
    immediate = '0; pc = '0; tbl_we = 1'b0; tbl_waddr = '0; tbl_wdata = '0;
    @(posedge clk);
    #1;

    //            rst wf fi eq ls br ca re imm   pc twe twa  twd   eb    ea ov un
    // reset state: branch held low, table cleared, no unf from a reset-cycle ret
    vecs.push_back('{0, 0, 0, 0, 0, 0, 1, 0,  3,    5, 0,  0,    0,  0,    0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 1, 1,  3,    5, 0,  0,    0,  0,    0, 0, 0});
    // table programming (index 24 is out of range and ignored)
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0,  0,    0, 1,  3,   52,  0,    0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0,  0,    0, 1,  7,  100,  0,    0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0,  0,    0, 1, 23, 1023,  0,    0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 24,    0, 1, 24,  555,  0,    0, 0, 0});
    // condition codes (each row's flag was written by the previous row)
    vecs.push_back('{1, 1, 4, 1, 0, 1, 0, 0,  3,    0, 0,  0,    0,  0,   52, 0, 0}); // 000
    vecs.push_back('{1, 1, 6, 1, 0, 1, 0, 0,  3,    0, 0,  0,    0,  1,   52, 0, 0}); // 100
    vecs.push_back('{1, 0, 0, 0, 0, 1, 0, 0,  7,    0, 0,  0,    0,  1,  100, 0, 0}); // 110
    vecs.push_back('{1, 0, 0, 1, 0, 1, 0, 0,  7,    0, 0,  0,    0,  0,  100, 0, 0}); // 110
    vecs.push_back('{1, 1, 7, 0, 1, 1, 0, 0,  7,    0, 0,  0,    0,  0,  100, 0, 0}); // 110
    vecs.push_back('{1, 1, 2, 0, 0, 1, 0, 0, 23,    0, 0,  0,    0,  0, 1023, 0, 0}); // 111
    vecs.push_back('{1, 0, 0, 0, 1, 1, 0, 0, 24,    0, 0,  0,    0,  1,    0, 0, 0}); // 010, imm out of range
    vecs.push_back('{1, 1, 3, 0, 0, 1, 0, 0,  0,    0, 0,  0,    0,  0,    0, 0, 0}); // 010
    vecs.push_back('{1, 1, 5, 1, 0, 1, 0, 0,  3,    0, 0,  0,    0,  1,   52, 0, 0}); // 011
    vecs.push_back('{1, 0, 0, 0, 0, 1, 0, 0,  3,    0, 0,  0,    0,  1,   52, 0, 0}); // 101
    vecs.push_back('{1, 1, 1, 0, 1, 1, 0, 0,  3,    0, 0,  0,    0,  0,   52, 0, 0}); // 101
    vecs.push_back('{1, 1, 0, 0, 0, 1, 0, 0,  3,    0, 0,  0,    0,  0,   52, 0, 0}); // 001
    vecs.push_back('{1, 1, 1, 1, 0, 1, 0, 0,  3,    0, 0,  0,    0,  0,   52, 0, 0}); // 000 read-before-write
    vecs.push_back('{1, 1, 1, 1, 0, 1, 0, 0,  3,    0, 0,  0,    0,  1,   52, 0, 0}); // 001
    vecs.push_back('{1, 1, 7, 0, 0, 0, 0, 0,  3,    0, 0,  0,    0,  0,   52, 0, 0}); // idle
    vecs.push_back('{1, 0, 0, 1, 1, 1, 0, 0,  3,    0, 1,  3,   77,  0,   52, 0, 0}); // 111, old entry
    vecs.push_back('{1, 0, 0, 0, 0, 1, 0, 0,  3,    0, 0,  0,    0,  0,   77, 0, 0}); // new entry
    // RAS: five calls overflow a 4-deep stack, then five returns
    vecs.push_back('{1, 0, 0, 0, 0, 1, 1, 0,  7,   10, 0,  0,    0,  1,  100, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 0,  7,   20, 0,  0,    0,  1,  100, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 0,  7,   30, 0,  0,    0,  1,  100, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 0,  7,   40, 0,  0,    0,  1,  100, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 0,  7,   50, 0,  0,    0,  1,  100, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 1,  7,    0, 0,  0,    0,  1,   51, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 1,  7,    0, 0,  0,    0,  1,   41, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 1,  7,    0, 0,  0,    0,  1,   31, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 1,  7,    0, 0,  0,    0,  1,   21, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 1,  7,    0, 0,  0,    0,  0,    0, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0,  0,    0, 0,  0,    0,  0,    0, 1, 1});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0,  0,    0, 0,  0,    0,  0,    0, 1, 0});
    // priority: ret beats call beats branch
    vecs.push_back('{1, 0, 0, 0, 0, 1, 1, 0,  7,   10, 0,  0,    0,  1,  100, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 1,  7,   60, 0,  0,    0,  1,   11, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 1,  7,    0, 0,  0,    0,  0,    0, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0,  0,    0, 0,  0,    0,  0,    0, 1, 1});
    vecs.push_back('{1, 0, 0, 0, 0, 1, 1, 1,  7,   70, 0,  0,    0,  0,    0, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 1,  7,    0, 0,  0,    0,  0,    0, 1, 1});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0,  0,    0, 0,  0,    0,  0,    0, 1, 1});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 0,  0,    0, 0,  0,    0,  0,    0, 1, 0});
    // pc+1 wraps at 2**ADDR_W
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 0,  7, 1023, 0,  0,    0,  1,  100, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 1,  7,    0, 0,  0,    0,  1,    0, 1, 0});

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // reset mid-sequence: pending push dropped, RAS/flag/table/ovf cleared
    apply('{1, 0, 0, 0, 0, 0, 1, 0,  7, 100, 0, 0, 0,  1, 100, 1, 0});
    apply('{1, 0, 0, 0, 0, 0, 1, 0,  7, 200, 0, 0, 0,  1, 100, 1, 0});
    apply('{0, 0, 0, 0, 0, 0, 1, 0,  7, 300, 0, 0, 0,  0, 100, 1, 0});
    apply('{1, 0, 0, 0, 0, 0, 0, 1,  7,   0, 0, 0, 0,  0,   0, 0, 0});
    apply('{1, 0, 0, 0, 0, 1, 0, 0,  3,   0, 0, 0, 0,  1,   0, 0, 1});
    apply('{1, 0, 0, 1, 0, 1, 0, 0,  7,   0, 0, 0, 0,  0,   0, 0, 0});

    // statistics: 3 taken, 2 not taken, then reset
    apply('{0, 0, 0, 0, 0, 0, 0, 0,  0,   0, 0, 0, 0,  0,   0, 0, 0});
    apply('{1, 1, 4, 0, 0, 0, 0, 0,  0,   0, 0, 0, 0,  0,   0, 0, 0});
    apply('{1, 0, 0, 1, 0, 1, 0, 0,  0,   0, 0, 0, 0,  1,   0, 0, 0});
    apply('{1, 0, 0, 1, 0, 1, 0, 0,  0,   0, 0, 0, 0,  1,   0, 0, 0});
    apply('{1, 1, 7, 1, 0, 1, 0, 0,  0,   0, 0, 0, 0,  1,   0, 0, 0});
    apply('{1, 0, 0, 0, 0, 1, 0, 0,  0,   0, 0, 0, 0,  0,   0, 0, 0});
    apply('{1, 0, 0, 0, 0, 1, 0, 0,  0,   0, 0, 0, 0,  0,   0, 0, 0});
`ifdef BRANCH_STATS_EN
    chk("taken_cnt",     vidx, int'(taken_cnt),     3);
    chk("not_taken_cnt", vidx, int'(not_taken_cnt), 2);
`else
    chk("taken_cnt",     vidx, int'(taken_cnt),     0);
    chk("not_taken_cnt", vidx, int'(not_taken_cnt), 0);
`endif
    apply('{0, 0, 0, 0, 0, 1, 0, 0,  0,   0, 0, 0, 0,  0,   0, 0, 0});
    chk("taken_cnt_rst",     vidx, int'(taken_cnt),     0);
    chk("not_taken_cnt_rst", vidx, int'(not_taken_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Parametrised successor of the decoder's branch unit.
- Holds a writable flag/condition register and a run-time-programmable branch target table, replacing the fixed immediate-to-address case list.
- Adds a return-address stack (RAS) for call/return.
- Sits between instruction decode and the PC mux; drives the branch decision and target each cycle.

Parameters:
ADDR_W, 10, width of PC/target address
IMM_W, 5, width of branch immediate (table index)
TBL_DEPTH, 32, target table entries (<= 2**IMM_W)
RAS_DEPTH, 4, return-address stack entries (power of 2, >= 2)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-low reset (acts at posedge clk when 0)
equal  input  1  comparator equal result
less  input  1  comparator less-than result
w_flag  input  1  load flag_in into flag register
flag_in  input  3  new condition code
branch_instr  input  1  conditional branch in decode
call_instr  input  1  unconditional call in decode
ret_instr  input  1  return in decode
immediate  input  IMM_W  target table index
pc  input  ADDR_W  current PC
tbl_we  input  1  target table write enable
tbl_waddr  input  IMM_W  table write index
tbl_wdata  input  ADDR_W  table write data
address  output  ADDR_W  branch/call/return target
branch  output  1  take redirect this cycle
ras_ovf  output  1  sticky: push while RAS full
ras_unf  output  1  one-cycle pulse: return on empty RAS
taken_cnt  output  16  taken redirects (optional feature)
not_taken_cnt  output  16  not-taken conditional branches (optional feature)

Behaviour:
- Reset (reset==0 at posedge): flag register=3'b000; all table entries=0; RAS empty (count=0, ptr=0); ras_ovf=0; ras_unf=0; counters=0. branch=0 while reset==0.
- branch/address are combinational from current inputs and registered state. All state updates on posedge clk.
- Condition codes, evaluated on the registered flag:
  - 000 !equal; 001 equal; 010 less; 011 less|equal
  - 100 always; 101 !less; 110 !less&!equal; 111 never
- Priority when several instr inputs are high: ret_instr > call_instr > branch_instr. Lower-priority inputs are ignored that cycle; no push/pop from them.
- branch_instr: branch = cond; address = table[immediate].
- call_instr:
  - branch = 1; address = table[immediate].
  - Push pc+1 (mod 2**ADDR_W) at the clock edge.
- ret_instr:
  - If RAS non-empty: branch = 1; address = top entry; pop at the edge.
  - If RAS empty: branch = 0; address = 0; ras_unf = 1 next cycle for exactly one cycle.
- No instruction active: branch = 0; address = table[immediate] (don't-care, but deterministic).
- immediate >= TBL_DEPTH: address = 0; the branch decision is unaffected.
- RAS full + push: oldest entry is overwritten (circular); count stays RAS_DEPTH; ras_ovf set, sticky until reset.
- Flag write in the same cycle as a branch: the branch uses the old flag (read-before-write).
- Table write to the index being looked up in the same cycle: lookup returns the old entry.
- tbl_waddr >= TBL_DEPTH: write ignored.
- Reset mid-sequence: the RAS is emptied; pending pushes/pops in that cycle are discarded.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - taken_cnt increments on every cycle with branch=1.
  - not_taken_cnt increments on branch_instr (winning priority) with cond=0.
  - Both saturate at 16'hFFFF; reset to 0.
- Undefined: both ports tied to 0; no counter logic.

Test Plan:
- Reset, then tbl_we writes index 3 = 10'd52. branch_instr=1, immediate=3, flag=100 -> branch=1, address=52.
- flag=110, equal=0, less=0 -> branch=1; equal=1 -> branch=0; flag=111 -> branch=0 for any inputs.
- Same cycle: w_flag=1 (flag_in=001) with branch_instr=1 and old flag=000, equal=1 -> branch=0. Next cycle same inputs -> branch=1.
- RAS_DEPTH=4: calls from pc=10,20,30,40,50 -> ras_ovf=1. Then five rets return 51,41,31,21 with branch=1; the fifth gives branch=0 and a ras_unf pulse.
- Simultaneous call_instr+ret_instr with RAS holding 11 -> ret wins: address=11, RAS empty after the edge, no push.
- BRANCH_STATS_EN: 3 taken branches + 2 not-taken -> taken_cnt=3, not_taken_cnt=2. Drive reset=0 for one cycle -> both 0.
